mux_scan_nx1: RTL and testbench
===============================

# mux_scan_nx1

Parametrised, registered N-to-1 multiplexer with a built-in channel scanner. In manual mode it forwards the externally selected channel; in auto mode an internal pointer steps through all channels, holding each for a programmable dwell time. It generalises the fixed 8-to-1 combinational mux to arbitrary width and channel count, and is used to time-share one downstream consumer (display, serial TX, logger) across several sources.

## Interface

Parameters:
- WIDTH, 4: bits per channel, ≥1.
- CHANNELS, 8: number of input channels, ≥2.
- DWELL, 2: cycles each channel is held in auto mode, ≥1.
- SELW, clog2(CHANNELS): select width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 freezes all state.
- mode  input  1  0 = manual select, 1 = auto scan.
- sel_in  input  SELW  manual channel select; ignored in auto mode.
- data_in  input  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- out  output  WIDTH  registered selected data.
- sel_out  output  SELW  channel index of the data currently in `out`.
- valid  output  1  `out` was loaded on the last edge.
- wrap  output  1  one-cycle pulse: auto scan left channel CHANNELS-1 for channel 0.

## Operation

- Internal state: `ptr` (SELW bits, current scan channel), `dwell_cnt` (clog2(DWELL) bits, minimum 1).
- Reset (async, while rst=1): out=0, sel_out=0, valid=0, wrap=0, ptr=0, dwell_cnt=0.
- en=0: out, sel_out, ptr and dwell_cnt hold; valid=0 and wrap=0 on the next edge.
- Manual (mode=0, en=1):
  - If sel_in < CHANNELS: out←data_in[sel_in], sel_out←sel_in, valid←1, ptr←sel_in, dwell_cnt←0.
  - If sel_in ≥ CHANNELS (non-power-of-2 CHANNELS only): out←0, valid←0, sel_out and ptr hold, dwell_cnt←0.
  - wrap←0.
- Auto (mode=1, en=1):
  - out←data_in[ptr], sel_out←ptr, valid←1.
  - If dwell_cnt = DWELL-1: dwell_cnt←0, ptr←(ptr = CHANNELS-1) ? 0 : ptr+1, and wrap←1 only when ptr = CHANNELS-1. Otherwise dwell_cnt←dwell_cnt+1, ptr holds, wrap←0.
  - DWELL=1 advances ptr every enabled cycle.
- Mode switch:
  - Manual→auto: the scan resumes from the last manual channel with a full dwell.
  - Auto→manual: takes effect on the same edge; dwell_cnt clears.
- data_in is sampled at every enabled edge, so a source change during a dwell shows up in `out` on the next cycle.
- ptr never exceeds CHANNELS-1 in any mode.

## Timing

- Latency: 1 cycle from data_in, sel_in or mode to out, sel_out and valid.
- Auto-mode sequence with en held high: each channel appears in out for exactly DWELL consecutive cycles. The full period is CHANNELS*DWELL cycles.
- wrap asserts in the same cycle that `out` shows the last dwell cycle of channel CHANNELS-1. The next cycle shows channel 0.
- en deassertion mid-dwell pauses the dwell count; it does not restart it. After re-enable, the remaining dwell cycles complete.
- rst mid-scan: outputs clear immediately (asynchronous). After release, the first enabled auto edge loads channel 0 with a full dwell.
- rst and en together: rst wins.
- No combinational path from inputs to outputs.

## Test plan

All scenarios use defaults (WIDTH=4, CHANNELS=8, DWELL=2) and data_in channel k = k+3, i.e. channels 0..7 hold 3..10.

- Reset: assert rst mid-cycle with out≠0 → out=0, sel_out=0, valid=0, wrap=0 before the next clk edge.
- Manual sweep: mode=0, en=1, sel_in stepped 0..7 one per cycle → one cycle later each step gives out=3..10, sel_out=0..7, valid=1, wrap=0 throughout.
- Auto scan: mode=1, en=1 for 16 cycles from reset → out = 3,3,4,4,…,10,10; wrap=1 only on the second cycle with out=10; the next cycle gives out=3, sel_out=0.
- Pause: in auto, drop en for 3 cycles after the first cycle of channel 2 → valid=0 for 3 cycles, out holds 5. After re-enable, out=5 for one more cycle, then 6.
- Mode switch: manual sel_in=5, then mode=1 → out=8 for 2 cycles, then 9, 9, then 10, 10 with wrap=1 on the last 10, then 3.
- DWELL=1 override: auto for 8 cycles → out = 3..10, one channel per cycle, with wrap=1 on out=10.

Source files
------------

// File: rtl/mux_scan_nx1.sv
//------------------------------------------------------------------------------
// mux_scan_nx1 : registered N-to-1 mux with manual select or auto channel scan
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_nx1 #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 2,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           sel_out,
    output logic                      valid,
    output logic                      wrap
);

    localparam int            DCW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int            NPAD       = 1 << SELW;
    localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [SELW-1:0] LAST_CH    = SELW'(CHANNELS - 1);
    localparam logic [SELW:0]   CH_LIM     = (SELW + 1)'(CHANNELS);

    logic [SELW-1:0]  ptr;
    logic [DCW-1:0]   dwell_cnt;
    logic             sel_ok;
    logic [WIDTH-1:0] chan [NPAD];

    // Unused select codes of a non-power-of-2 mux read as zero.
    for (genvar k = 0; k < NPAD; k++) begin : g_chan
        if (k < CHANNELS) begin : g_live
            assign chan[k] = data_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[k] = '0;
        end
    end

    assign sel_ok = ({1'b0, sel_in} < CH_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            sel_out   <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            ptr       <= '0;
            dwell_cnt <= '0;
        end else if (!en) begin
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (!mode) begin
            wrap      <= 1'b0;
            dwell_cnt <= '0;
            if (sel_ok) begin
                out     <= chan[sel_in];
                sel_out <= sel_in;
                valid   <= 1'b1;
                ptr     <= sel_in;
            end else begin
                out   <= '0;
                valid <= 1'b0;
            end
        end else begin
            out     <= chan[ptr];
            sel_out <= ptr;
            valid   <= 1'b1;
            // Last cycle of this channel's dwell: step on, flag the wrap to 0.
            if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt <= '0;
                ptr       <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
                wrap      <= (ptr == LAST_CH);
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
                wrap      <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_nx1.sv
//------------------------------------------------------------------------------
// tb_mux_scan_nx1 : three configurations of mux_scan_nx1 against a scan-position model
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_scan_nx1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  sel_a = '0;
    logic [2:0]  sel_c = '0;
    logic [31:0] data_a = '0;
    logic [29:0] data_c = '0;

    logic [3:0] out_a, out_b;
    logic [4:0] out_c;
    logic [2:0] so_a, so_b, so_c;
    logic       v_a, v_b, v_c, w_a, w_b, w_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: scan position counts dwell cycles from the start of channel 0.
    int NC[3] = '{8, 8, 6};
    int ND[3] = '{2, 1, 3};
    int m_out[3], m_sel[3], m_val[3], m_wrap[3], m_pos[3];

    always #5 clk = ~clk;

    mux_scan_nx1 u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_a), .data_in(data_a),
        .out(out_a), .sel_out(so_a), .valid(v_a), .wrap(w_a)
    );

    mux_scan_nx1 #(.DWELL(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_a), .data_in(data_a),
        .out(out_b), .sel_out(so_b), .valid(v_b), .wrap(w_b)
    );

    mux_scan_nx1 #(.WIDTH(5), .CHANNELS(6), .DWELL(3)) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_c), .data_in(data_c),
        .out(out_c), .sel_out(so_c), .valid(v_c), .wrap(w_c)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int chan_val(input int id, input int ch);
        if (id == 2) return int'((data_c >> (ch * 5)) & 30'h1f);
        return int'((data_a >> (ch * 4)) & 32'hf);
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 3; id++) begin
            m_out[id] = 0; m_sel[id] = 0; m_val[id] = 0; m_wrap[id] = 0; m_pos[id] = 0;
        end
    endtask

    task automatic model_step();
        int c, d, s;
        if (rst) begin
            model_reset();
            return;
        end
        for (int id = 0; id < 3; id++) begin
            c = NC[id];
            d = ND[id];
            s = (id == 2) ? int'(sel_c) : int'(sel_a);
            if (!en) begin
                m_val[id] = 0; m_wrap[id] = 0;
            end else if (!mode) begin
                m_wrap[id] = 0;
                if (s < c) begin
                    m_out[id] = chan_val(id, s); m_sel[id] = s; m_val[id] = 1;
                    m_pos[id] = s * d;
                end else begin
                    m_out[id] = 0; m_val[id] = 0;
                    m_pos[id] = (m_pos[id] / d) * d;
                end
            end else begin
                m_out[id]  = chan_val(id, m_pos[id] / d);
                m_sel[id]  = m_pos[id] / d;
                m_val[id]  = 1;
                m_wrap[id] = (m_pos[id] == c * d - 1) ? 1 : 0;
                m_pos[id]  = (m_pos[id] + 1) % (c * d);
            end
        end
    endtask

    task automatic cmp_dut(input int id, input int o, input int s, input int v, input int w);
        chk($sformatf("dut%0d.out", id), o, m_out[id]);
        chk($sformatf("dut%0d.sel_out", id), s, m_sel[id]);
        chk($sformatf("dut%0d.valid", id), v, m_val[id]);
        chk($sformatf("dut%0d.wrap", id), w, m_wrap[id]);
    endtask

    always @(negedge clk) begin
        cmp_dut(0, int'(out_a), int'(so_a), int'(v_a), int'(w_a));
        cmp_dut(1, int'(out_b), int'(so_b), int'(v_b), int'(w_b));
        cmp_dut(2, int'(out_c), int'(so_c), int'(v_c), int'(w_c));
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst.out", int'(out_a), 0);
        chk("async_rst.sel_out", int'(so_a), 0);
        chk("async_rst.valid", int'(v_a), 0);
        chk("async_rst.wrap", int'(w_a), 0);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int seq_ms[7];
        model_reset();
        for (int k = 0; k < 8; k++) data_a[k*4 +: 4] = 4'(k + 3);
        for (int k = 0; k < 6; k++) data_c[k*5 +: 5] = 5'($urandom_range(0, 31));
        cyc(); cyc();
        chk("reset.out", int'(out_a), 0);
        chk("reset.valid", int'(v_a), 0);
        rst = 1'b0;

        // Manual sweep; sel 6,7 are out of range for the 6-channel instance.
        en = 1'b1; mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sel_a = 3'(k); sel_c = 3'(k);
            cyc();
            chk("manual.out", int'(out_a), k + 3);
            chk("manual.sel_out", int'(so_a), k);
            chk("manual.valid", int'(v_a), 1);
            chk("manual.wrap", int'(w_a), 0);
            chk("manual_c.valid", int'(v_c), (k < 6) ? 1 : 0);
        end

        async_reset();

        // Auto scan from reset.
        mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("auto.out", int'(out_a), 3 + i / 2);
            chk("auto.wrap", int'(w_a), (i == 15) ? 1 : 0);
            if (i < 8) begin
                chk("dwell1.out", int'(out_b), 3 + i);
                chk("dwell1.wrap", int'(w_b), (i == 7) ? 1 : 0);
            end
        end
        cyc();
        chk("auto_wrap_next.out", int'(out_a), 3);
        chk("auto_wrap_next.sel_out", int'(so_a), 0);

        // Advance to the first cycle of channel 2, then pause.
        for (int i = 0; i < 4; i++) cyc();
        chk("pause_pre.out", int'(out_a), 5);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pause.valid", int'(v_a), 0);
            chk("pause.out", int'(out_a), 5);
        end
        en = 1'b1;
        cyc();
        chk("resume.out", int'(out_a), 5);
        cyc();
        chk("resume_next.out", int'(out_a), 6);

        // Manual channel 5, then auto resumes there with a full dwell.
        mode = 1'b0; sel_a = 3'd5; sel_c = 3'd2;
        cyc();
        chk("switch_manual.out", int'(out_a), 8);
        mode = 1'b1;
        seq_ms = '{8, 8, 9, 9, 10, 10, 3};
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("switch_auto.out", int'(out_a), seq_ms[i]);
            chk("switch_auto.wrap", int'(w_a), (i == 5) ? 1 : 0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            en     = ($urandom_range(0, 3) != 0);
            mode   = ($urandom_range(0, 2) != 0);
            sel_a  = 3'($urandom_range(0, 7));
            sel_c  = 3'($urandom_range(0, 7));
            data_a = $urandom;
            data_c = 30'($urandom);
            if ($urandom_range(0, 60) == 0) async_reset();
            else cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
